// File: rtl/wb_regfile.sv
// Architectural register state at the end of the write-back bus: 31 GPRs, HI, LO,
// with same-cycle write bypass on every read port and a committed-GPR-write counter.
module wb_regfile #(
    parameter int WB_TO_RF_WD = 104,
    parameter int CNT_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WB_TO_RF_WD-1:0] wb_to_rf_bus,
    input  logic [4:0]             raddr1,
    output logic [31:0]            rdata1,
    input  logic [4:0]             raddr2,
    output logic [31:0]            rdata2,
    output logic [31:0]            hi_rdata,
    output logic [31:0]            lo_rdata,
    output logic [CNT_W-1:0]       commit_cnt
);

    logic        lo_we;
    logic [31:0] lo_wdata;
    logic        hi_we;
    logic [31:0] hi_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        gpr_write;

    logic [31:0]      regs [1:31];
    logic [31:0]      hi_q;
    logic [31:0]      lo_q;
    logic [CNT_W-1:0] cnt_q;

    assign lo_we    = wb_to_rf_bus[103];
    assign lo_wdata = wb_to_rf_bus[102:71];
    assign hi_we    = wb_to_rf_bus[70];
    assign hi_wdata = wb_to_rf_bus[69:38];
    assign rf_we    = wb_to_rf_bus[37];
    assign rf_waddr = wb_to_rf_bus[36:32];
    assign rf_wdata = wb_to_rf_bus[31:0];

    // r0 is not stored, so a write to it is neither performed nor counted
    assign gpr_write = rf_we && (rf_waddr != 5'd0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 1; i < 32; i++) begin
                regs[i] <= '0;
            end
            hi_q  <= '0;
            lo_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (gpr_write) begin
                regs[rf_waddr] <= rf_wdata;
                cnt_q          <= cnt_q + CNT_W'(1);
            end
            if (hi_we) begin
                hi_q <= hi_wdata;
            end
            if (lo_we) begin
                lo_q <= lo_wdata;
            end
        end
    end

    always_comb begin
        rdata1 = '0;
        if (rst && (raddr1 != 5'd0)) begin
            if (rf_we && (rf_waddr == raddr1)) begin
                rdata1 = rf_wdata;
            end else begin
                rdata1 = regs[raddr1];
            end
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && (raddr2 != 5'd0)) begin
            if (rf_we && (rf_waddr == raddr2)) begin
                rdata2 = rf_wdata;
            end else begin
                rdata2 = regs[raddr2];
            end
        end
    end

    // Reset forces every read to zero so nothing pending on the bus leaks through
    always_comb begin
        hi_rdata   = '0;
        lo_rdata   = '0;
        commit_cnt = '0;
        if (rst) begin
            hi_rdata   = hi_we ? hi_wdata : hi_q;
            lo_rdata   = lo_we ? lo_wdata : lo_q;
            commit_cnt = cnt_q;
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: expectations are queued as stimulus is driven
// and drained against the DUT outputs mid-cycle.
module tb_wb_regfile;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [103:0] bus = '0;
    logic [4:0]   raddr1 = '0;
    logic [4:0]   raddr2 = '0;
    logic [31:0]  rdata1, rdata2, hi_rdata, lo_rdata, cnt_main;
    logic [31:0]  s_rdata1, s_rdata2, s_hi_rdata, s_lo_rdata;
    logic [3:0]   cnt_small;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];

    localparam int S_RD1 = 0, S_RD2 = 1, S_HI = 2, S_LO = 3, S_CNT = 4, S_CNT4 = 5;

    wb_regfile dut (
        .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
        .raddr1(raddr1), .rdata1(rdata1), .raddr2(raddr2), .rdata2(rdata2),
        .hi_rdata(hi_rdata), .lo_rdata(lo_rdata), .commit_cnt(cnt_main)
    );

    wb_regfile #(.CNT_W(4)) dut_small (
        .clk(clk), .rst(rst), .wb_to_rf_bus(bus),
        .raddr1(raddr1), .rdata1(s_rdata1), .raddr2(raddr2), .rdata2(s_rdata2),
        .hi_rdata(s_hi_rdata), .lo_rdata(s_lo_rdata), .commit_cnt(cnt_small)
    );

    always #5 clk = ~clk;

    function automatic logic [103:0] mk_bus(input logic lwe, input logic [31:0] lwd,
                                            input logic hwe, input logic [31:0] hwd,
                                            input logic rwe, input logic [4:0] wa,
                                            input logic [31:0] wd);
        return {lwe, lwd, hwe, hwd, rwe, wa, wd};
    endfunction

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            S_RD1:   return rdata1;
            S_RD2:   return rdata2;
            S_HI:    return hi_rdata;
            S_LO:    return lo_rdata;
            S_CNT:   return cnt_main;
            default: return {28'd0, cnt_small};
        endcase
    endfunction

    task automatic push(input string name, input int sel, input logic [31:0] val);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.val  = val;
        exp_q.push_back(e);
    endtask

    task automatic test_reset();
        // held in reset from time 0
        @(negedge clk);
        push("rst_rd1", S_RD1, 0); push("rst_hi", S_HI, 0);
        push("rst_lo", S_LO, 0);   push("rst_cnt", S_CNT, 0);
        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: ;
                1: begin
                    @(negedge clk);
                    rst = 1'b1;
                    bus = mk_bus(1, 32'd2, 1, 32'd1, 1, 5'd5, 32'h1234);
                    raddr1 = 5'd5;
                    push("pre_byp_rd1", S_RD1, 32'h1234); push("pre_byp_hi", S_HI, 1);
                    push("pre_byp_lo", S_LO, 2);          push("pre_byp_cnt", S_CNT, 0);
                end
                2: begin
                    @(negedge clk);
                    bus = '0;
                    push("pre_rd1", S_RD1, 32'h1234); push("pre_hi", S_HI, 1);
                    push("pre_lo", S_LO, 2);          push("pre_cnt", S_CNT, 1);
                end
                3: begin
                    @(posedge clk);
                    #2;
                    bus = mk_bus(0, 0, 1, 32'd9, 1, 5'd5, 32'h99);
                    rst = 1'b0;
                    push("mid_rst_rd1", S_RD1, 0); push("mid_rst_hi", S_HI, 0);
                    push("mid_rst_lo", S_LO, 0);   push("mid_rst_cnt", S_CNT, 0);
                end
                default: begin
                    @(posedge clk);
                    @(negedge clk);
                    rst = 1'b1;
                    bus = '0;
                    push("no_write_in_rst_rd1", S_RD1, 0); push("no_write_in_rst_hi", S_HI, 0);
                    push("no_write_in_rst_cnt", S_CNT, 0);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
        for (int i = 0; i < 32; i++) begin
            raddr1 = 5'(i);
            raddr2 = 5'(31 - i);
            #1;
            push($sformatf("post_rst_rd1_r%0d", i), S_RD1, 0);
            push($sformatf("post_rst_rd2_r%0d", 31 - i), S_RD2, 0);
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_write_bypass();
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            if (ph == 0) begin
                bus = mk_bus(0, 0, 0, 0, 1, 5'd7, 32'hDEADBEEF);
                raddr1 = 5'd7;
                raddr2 = 5'd0;
                push("wr_byp_rd1", S_RD1, 32'hDEADBEEF); push("wr_byp_cnt", S_CNT, 0);
            end else begin
                bus = '0;
                push("wr_arr_rd1", S_RD1, 32'hDEADBEEF); push("wr_arr_cnt", S_CNT, 1);
            end
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_reg0();
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            bus = (ph == 0) ? mk_bus(0, 0, 0, 0, 1, 5'd0, 32'hFFFFFFFF) : '0;
            raddr1 = 5'd0;
            raddr2 = 5'd0;
            push($sformatf("r0_rd1_ph%0d", ph), S_RD1, 0);
            push($sformatf("r0_rd2_ph%0d", ph), S_RD2, 0);
            push($sformatf("r0_cnt_ph%0d", ph), S_CNT, 1);
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_hilo();
        for (int ph = 0; ph < 3; ph++) begin
            @(negedge clk);
            case (ph)
                0: begin
                    bus = mk_bus(1, 32'h0000BBBB, 1, 32'hAAAA0000, 0, 0, 0);
                    push("hilo_byp_hi", S_HI, 32'hAAAA0000); push("hilo_byp_lo", S_LO, 32'h0000BBBB);
                end
                1: begin
                    bus = mk_bus(1, 32'd5, 0, 32'h12345678, 0, 0, 0);
                    push("lo_only_hi", S_HI, 32'hAAAA0000); push("lo_only_lo", S_LO, 5);
                end
                default: begin
                    bus = '0;
                    push("hilo_arr_hi", S_HI, 32'hAAAA0000); push("hilo_arr_lo", S_LO, 5);
                    push("hilo_cnt", S_CNT, 1);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_dual_port();
        for (int ph = 0; ph < 2; ph++) begin
            @(negedge clk);
            bus = (ph == 0) ? mk_bus(0, 0, 0, 0, 1, 5'd31, 32'h55) : '0;
            raddr1 = 5'd31;
            raddr2 = 5'd31;
            push($sformatf("dual_rd1_ph%0d", ph), S_RD1, 32'h55);
            push($sformatf("dual_rd2_ph%0d", ph), S_RD2, 32'h55);
            push($sformatf("dual_cnt_ph%0d", ph), S_CNT, (ph == 0) ? 1 : 2);
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int ph = 0; ph < 6; ph++) begin
            @(negedge clk);
            raddr1 = 5'd3;
            raddr2 = 5'd7;
            case (ph)
                0: begin
                    bus = '0;
                    push("b2b_init_rd1", S_RD1, 0); push("b2b_other_rd2", S_RD2, 32'hDEADBEEF);
                end
                1: begin
                    bus = mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h11);
                    push("b2b_w1_rd1", S_RD1, 32'h11); push("b2b_w1_rd2", S_RD2, 32'hDEADBEEF);
                end
                2: begin
                    bus = mk_bus(0, 0, 0, 0, 1, 5'd3, 32'h22);
                    push("b2b_w2_rd1", S_RD1, 32'h22); push("b2b_w2_cnt", S_CNT, 3);
                end
                3: begin
                    bus = mk_bus(0, 0, 0, 0, 1, 5'd4, 32'h44);
                    raddr2 = 5'd4;
                    push("b2b_nobyp_rd1", S_RD1, 32'h22); push("b2b_r4_rd2", S_RD2, 32'h44);
                    push("b2b_w3_cnt", S_CNT, 4);
                end
                4: begin
                    bus = '0;
                    raddr2 = 5'd4;
                    push("b2b_arr_rd1", S_RD1, 32'h22); push("b2b_arr_rd2", S_RD2, 32'h44);
                    push("b2b_cnt", S_CNT, 5);
                end
                default: begin
                    bus = '0;
                    raddr1 = 5'd5;
                    push("b2b_r5_cleared", S_RD1, 0);
                end
            endcase
            #2;
            while (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (observe(e.sel) !== e.val) begin
                    errors++;
                    $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
                end
            end
        end
    endtask

    task automatic test_counter_wrap();
        int hi_writes = 0;
        @(negedge clk);
        rst = 1'b0;
        bus = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            bus = mk_bus(0, 0, 0, 0, 1, 5'((i % 31) + 1), 32'(i));
            if ((i % 3 == 2) && (hi_writes < 5)) begin
                @(negedge clk);
                bus = mk_bus(0, 0, 1, 32'(i + 100), 0, 0, 0);
                hi_writes++;
            end
        end
        @(negedge clk);
        bus = '0;
        push("wrap_cnt4", S_CNT4, 1);
        push("wrap_cnt32", S_CNT, 17);
        push("wrap_hi", S_HI, 114);
        #2;
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (observe(e.sel) !== e.val) begin
                errors++;
                $display("[TB] FAIL %s: got %h expected %h", e.name, observe(e.sel), e.val);
            end
        end
    endtask

    initial begin
        $display("[TB] starting wb_regfile bench");
        test_reset();
        test_write_bypass();
        test_reg0();
        test_hilo();
        test_dual_port();
        test_back_to_back();
        test_counter_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
